// File: rtl/renode_ahb_arbiter.sv
// Shares one AHB-Lite subordinate port between NumManagers managers, holding grants across bursts.
// Optional build macro: RENODE_AHB_ARBITER_FIXED_PRIORITY_EN selects fixed lowest-index priority instead of round-robin.
module renode_ahb_arbiter #(
    parameter int NumManagers  = 2,
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32
) (
    input  logic                             hclk,
    input  logic                             hresetn,

    input  logic [1:0]                       m_htrans [NumManagers],
    input  logic [AddressWidth-1:0]          m_haddr  [NumManagers],
    input  logic                             m_hwrite [NumManagers],
    input  logic [2:0]                       m_hsize  [NumManagers],
    input  logic [2:0]                       m_hburst [NumManagers],
    input  logic [DataWidth-1:0]             m_hwdata [NumManagers],
    output logic                             m_hready [NumManagers],
    output logic                             m_hresp  [NumManagers],
    output logic [DataWidth-1:0]             m_hrdata,

    output logic [1:0]                       s_htrans,
    output logic [AddressWidth-1:0]          s_haddr,
    output logic                             s_hwrite,
    output logic [2:0]                       s_hsize,
    output logic [2:0]                       s_hburst,
    output logic [DataWidth-1:0]             s_hwdata,
    output logic                             s_hready,
    input  logic                             s_hreadyout,
    input  logic                             s_hresp,
    input  logic [DataWidth-1:0]             s_hrdata,

    output logic [$clog2(NumManagers)-1:0]   grant,
    output logic [$clog2(NumManagers)-1:0]   data_owner
);

    localparam int IdxW = $clog2(NumManagers);

    localparam logic [1:0] TransIdle   = 2'd0;
    localparam logic [1:0] TransBusy   = 2'd1;
    localparam logic [1:0] TransNonseq = 2'd2;
    localparam logic [1:0] TransSeq    = 2'd3;
    localparam logic [2:0] BurstSingle = 3'd0;

    logic [IdxW-1:0]        grant_q, grant_d;
    logic [IdxW-1:0]        data_owner_q, data_owner_d;
    logic                   data_valid_q, data_valid_d;

    logic [NumManagers-1:0] req;
    logic [1:0]             owner_trans;
    logic [2:0]             owner_burst;
    logic                   hold;
    logic                   arb_en;
    logic                   pick_found;
    logic [IdxW-1:0]        pick_idx;

    always_comb begin
        for (int i = 0; i < NumManagers; i++) begin
            req[i] = m_htrans[i][1];
        end
    end

    assign owner_trans = m_htrans[grant_q];
    assign owner_burst = m_hburst[grant_q];

    // An undefined-length or fixed-length burst keeps the bus from its first NONSEQ onward.
    assign hold = (owner_trans == TransSeq) || (owner_trans == TransBusy) ||
                  ((owner_trans == TransNonseq) && (owner_burst != BurstSingle));

    assign arb_en = s_hreadyout && !hold;

`ifdef RENODE_AHB_ARBITER_FIXED_PRIORITY_EN

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = grant_q;
        for (int k = NumManagers - 1; k >= 0; k--) begin
            if (req[k]) begin
                pick_found = 1'b1;
                pick_idx   = IdxW'(k);
            end
        end
    end

`else

    logic [IdxW-1:0] rr_last_q, rr_last_d;

    // Walk the rotation backwards so the last hit is the first requester after rr_last.
    always_comb begin
        int cand;
        cand       = 0;
        pick_found = 1'b0;
        pick_idx   = grant_q;
        for (int k = NumManagers; k >= 1; k--) begin
            cand = int'(rr_last_q) + k;
            if (cand >= NumManagers) begin
                cand = cand - NumManagers;
            end
            if (req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IdxW'(cand);
            end
        end
    end

    always_comb begin
        rr_last_d = rr_last_q;
        if (arb_en && pick_found) begin
            rr_last_d = pick_idx;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            rr_last_q <= IdxW'(NumManagers - 1);
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

`endif

    always_comb begin
        grant_d      = grant_q;
        data_owner_d = data_owner_q;
        data_valid_d = data_valid_q;
        if (arb_en && pick_found) begin
            grant_d = pick_idx;
        end
        if (s_hreadyout) begin
            data_owner_d = grant_q;
            data_valid_d = (owner_trans == TransNonseq) || (owner_trans == TransSeq);
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            grant_q      <= '0;
            data_owner_q <= '0;
            data_valid_q <= 1'b0;
        end else begin
            grant_q      <= grant_d;
            data_owner_q <= data_owner_d;
            data_valid_q <= data_valid_d;
        end
    end

    always_comb begin
        s_htrans = hresetn ? owner_trans : TransIdle;
        s_haddr  = m_haddr[grant_q];
        s_hwrite = m_hwrite[grant_q];
        s_hsize  = m_hsize[grant_q];
        s_hburst = owner_burst;
        s_hwdata = m_hwdata[data_owner_q];
        s_hready = s_hreadyout;
        m_hrdata = s_hrdata;
    end

    // Responses only mean something for a real data phase; data_valid is cleared by reset too.
    always_comb begin
        for (int i = 0; i < NumManagers; i++) begin
            if (!hresetn) begin
                m_hready[i] = 1'b1;
            end else if ((IdxW'(i) == grant_q) || (IdxW'(i) == data_owner_q)) begin
                m_hready[i] = s_hreadyout;
            end else begin
                m_hready[i] = 1'b0;
            end
            m_hresp[i] = (IdxW'(i) == data_owner_q) && data_valid_q && s_hresp;
        end
    end

    assign grant      = grant_q;
    assign data_owner = data_owner_q;

endmodule

// File: tb/tb_renode_ahb_arbiter.sv
// Directed-vector bench for renode_ahb_arbiter with two managers.
module tb_renode_ahb_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] NONSEQ = 2'd2;
    localparam logic [1:0] SEQ    = 2'd3;
    localparam logic [2:0] SINGLE = 3'd0;
    localparam logic [2:0] INCR   = 3'd1;
    localparam logic [2:0] INCR4  = 3'd3;

    logic          hclk = 1'b0;
    logic          hresetn = 1'b1;
    logic [1:0]    m_htrans [N];
    logic [AW-1:0] m_haddr  [N];
    logic          m_hwrite [N];
    logic [2:0]    m_hsize  [N];
    logic [2:0]    m_hburst [N];
    logic [DW-1:0] m_hwdata [N];
    logic          m_hready [N];
    logic          m_hresp  [N];
    logic [DW-1:0] m_hrdata;
    logic [1:0]    s_htrans;
    logic [AW-1:0] s_haddr;
    logic          s_hwrite;
    logic [2:0]    s_hsize;
    logic [2:0]    s_hburst;
    logic [DW-1:0] s_hwdata;
    logic          s_hready;
    logic          s_hreadyout;
    logic          s_hresp;
    logic [DW-1:0] s_hrdata;
    logic [0:0]    grant;
    logic [0:0]    data_owner;

    int tests = 0;
    int fails = 0;

    renode_ahb_arbiter #(.NumManagers(N), .AddressWidth(AW), .DataWidth(DW)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .m_htrans(m_htrans), .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_hsize(m_hsize),
        .m_hburst(m_hburst), .m_hwdata(m_hwdata), .m_hready(m_hready), .m_hresp(m_hresp),
        .m_hrdata(m_hrdata),
        .s_htrans(s_htrans), .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
        .s_hburst(s_hburst), .s_hwdata(s_hwdata), .s_hready(s_hready),
        .s_hreadyout(s_hreadyout), .s_hresp(s_hresp), .s_hrdata(s_hrdata),
        .grant(grant), .data_owner(data_owner)
    );

    always #5 hclk = ~hclk;

    task automatic set_m(input int i, input logic [1:0] t, input logic [AW-1:0] a,
                         input logic w, input logic [2:0] b);
        m_htrans[i] = t;
        m_haddr[i]  = a;
        m_hwrite[i] = w;
        m_hsize[i]  = 3'd2;
        m_hburst[i] = b;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) begin
            set_m(i, IDLE, '0, 1'b0, SINGLE);
            m_hwdata[i] = '0;
        end
    endtask

    task automatic next_cycle();
        @(posedge hclk);
        #1;
    endtask

    task automatic test_reset();
        idle_all();
        s_hreadyout = 1'b1; s_hresp = 1'b0; s_hrdata = '0;
        #1 hresetn = 1'b0;
        repeat (2) @(posedge hclk);
        #1 hresetn = 1'b1;
        set_m(1, NONSEQ, 32'h200, 1'b0, INCR);
        #1;
        tests++; if (m_hready[1] !== 1'b0) begin fails++; $display("FAIL rst_m1_stalled got=%0b exp=0", m_hready[1]); end
        next_cycle();
        #1;
        tests++; if (grant !== 1'b1) begin fails++; $display("FAIL rst_m1_granted got=%0d exp=1", grant); end
        next_cycle();
        set_m(1, SEQ, 32'h204, 1'b0, INCR);
        set_m(0, NONSEQ, 32'h10, 1'b1, SINGLE);
        s_hresp = 1'b1; s_hrdata = 32'h1234;
        hresetn = 1'b0;
        #1;
        tests++; if (grant !== 1'b0) begin fails++; $display("FAIL rst_grant got=%0d exp=0", grant); end
        tests++; if (data_owner !== 1'b0) begin fails++; $display("FAIL rst_data_owner got=%0d exp=0", data_owner); end
        tests++; if (s_htrans !== IDLE) begin fails++; $display("FAIL rst_s_htrans got=%0d exp=0", s_htrans); end
        tests++; if (m_hready[0] !== 1'b1 || m_hready[1] !== 1'b1) begin fails++; $display("FAIL rst_hready got=%0b%0b exp=11", m_hready[1], m_hready[0]); end
        tests++; if (m_hresp[0] !== 1'b0 || m_hresp[1] !== 1'b0) begin fails++; $display("FAIL rst_hresp got=%0b%0b exp=00", m_hresp[1], m_hresp[0]); end
        tests++; if (m_hrdata !== 32'h1234) begin fails++; $display("FAIL rst_hrdata got=%0h exp=1234", m_hrdata); end
        next_cycle();
        s_hresp = 1'b0;
        set_m(1, IDLE, '0, 1'b0, SINGLE);
        hresetn = 1'b1;
        #1;
        tests++; if (grant !== 1'b0) begin fails++; $display("FAIL post_rst_grant got=%0d exp=0", grant); end
        tests++; if (s_htrans !== NONSEQ || s_haddr !== 32'h10 || s_hwrite !== 1'b1) begin fails++; $display("FAIL post_rst_addr got=%0d/%0h/%0b exp=2/10/1", s_htrans, s_haddr, s_hwrite); end
        tests++; if (m_hready[0] !== 1'b1) begin fails++; $display("FAIL post_rst_m0_ready got=%0b exp=1", m_hready[0]); end
        next_cycle();
        set_m(0, IDLE, '0, 1'b0, SINGLE);
        m_hwdata[0] = 32'hA5;
        #1;
        tests++; if (s_hwdata !== 32'hA5 || data_owner !== 1'b0) begin fails++; $display("FAIL post_rst_wdata got=%0h/%0d exp=a5/0", s_hwdata, data_owner); end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] exp_addr;
        for (int k = 0; k < 8; k++) begin
            if (k < 7) set_m(0, NONSEQ, 32'h20 + 32'(4 * ((k + 1) / 2)), 1'b0, SINGLE);
            else       set_m(0, IDLE, '0, 1'b0, SINGLE);
            set_m(1, NONSEQ, 32'h30 + 32'(4 * (k / 2)), 1'b0, SINGLE);
            #1;
            exp_addr = (k % 2 == 0) ? 32'h20 + 32'(4 * (k / 2)) : 32'h30 + 32'(4 * (k / 2));
            tests++; if (grant !== 1'(k % 2)) begin fails++; $display("FAIL rr_grant k=%0d got=%0d exp=%0d", k, grant, k % 2); end
            tests++; if (s_haddr !== exp_addr) begin fails++; $display("FAIL rr_addr k=%0d got=%0h exp=%0h", k, s_haddr, exp_addr); end
            if (k > 0) begin
                tests++; if (data_owner !== 1'((k - 1) % 2)) begin fails++; $display("FAIL rr_data_owner k=%0d got=%0d exp=%0d", k, data_owner, (k - 1) % 2); end
            end else begin
                tests++; if (m_hready[1] !== 1'b0) begin fails++; $display("FAIL rr_m1_stalled got=%0b exp=0", m_hready[1]); end
            end
            next_cycle();
        end
        idle_all();
        #1;
        tests++; if (grant !== 1'b1 || data_owner !== 1'b1) begin fails++; $display("FAIL rr_park got=%0d/%0d exp=1/1", grant, data_owner); end
        next_cycle();
    endtask

    task automatic test_burst_hold();
        set_m(1, NONSEQ, 32'h100, 1'b0, INCR4);
        set_m(0, NONSEQ, 32'h40, 1'b0, SINGLE);
        #1;
        tests++; if (s_haddr !== 32'h100 || m_hready[0] !== 1'b0) begin fails++; $display("FAIL burst_b0 got=%0h/%0b exp=100/0", s_haddr, m_hready[0]); end
        next_cycle();
        for (int b = 1; b < 4; b++) begin
            set_m(1, SEQ, 32'h100 + 32'(4 * b), 1'b0, INCR4);
            #1;
            tests++; if (grant !== 1'b1 || s_htrans !== SEQ || s_haddr !== 32'h100 + 32'(4 * b)) begin fails++; $display("FAIL burst_beat%0d got=%0d/%0d/%0h exp=1/3/%0h", b, grant, s_htrans, s_haddr, 32'h100 + 32'(4 * b)); end
            tests++; if (m_hready[0] !== 1'b0) begin fails++; $display("FAIL burst_m0_stall%0d got=%0b exp=0", b, m_hready[0]); end
            next_cycle();
        end
        set_m(1, IDLE, '0, 1'b0, SINGLE);
        #1;
        tests++; if (grant !== 1'b1 || s_htrans !== IDLE) begin fails++; $display("FAIL burst_idle got=%0d/%0d exp=1/0", grant, s_htrans); end
        next_cycle();
        #1;
        tests++; if (grant !== 1'b0 || s_haddr !== 32'h40 || m_hready[0] !== 1'b1) begin fails++; $display("FAIL burst_handover got=%0d/%0h/%0b exp=0/40/1", grant, s_haddr, m_hready[0]); end
        next_cycle();
        idle_all();
        next_cycle();
    endtask

    task automatic test_error();
        set_m(0, NONSEQ, 32'h50, 1'b1, SINGLE);
        set_m(1, NONSEQ, 32'h60, 1'b0, SINGLE);
        #1;
        tests++; if (grant !== 1'b0 || s_haddr !== 32'h50 || s_hwrite !== 1'b1) begin fails++; $display("FAIL err_addr got=%0d/%0h/%0b exp=0/50/1", grant, s_haddr, s_hwrite); end
        next_cycle();
        set_m(0, IDLE, '0, 1'b0, SINGLE);
        m_hwdata[0] = 32'h5A5A;
        s_hresp = 1'b1; s_hreadyout = 1'b0;
        #1;
        tests++; if (m_hresp[0] !== 1'b1 || m_hresp[1] !== 1'b0) begin fails++; $display("FAIL err_cycle1_resp got=%0b%0b exp=01", m_hresp[1], m_hresp[0]); end
        tests++; if (grant !== 1'b1 || data_owner !== 1'b0 || s_hwdata !== 32'h5A5A) begin fails++; $display("FAIL err_cycle1_route got=%0d/%0d/%0h exp=1/0/5a5a", grant, data_owner, s_hwdata); end
        tests++; if (m_hready[0] !== 1'b0 || m_hready[1] !== 1'b0) begin fails++; $display("FAIL err_cycle1_ready got=%0b%0b exp=00", m_hready[1], m_hready[0]); end
        next_cycle();
        s_hreadyout = 1'b1;
        #1;
        tests++; if (m_hresp[0] !== 1'b1 || m_hresp[1] !== 1'b0) begin fails++; $display("FAIL err_cycle2_resp got=%0b%0b exp=01", m_hresp[1], m_hresp[0]); end
        tests++; if (m_hready[0] !== 1'b1 || s_haddr !== 32'h60) begin fails++; $display("FAIL err_cycle2_ready got=%0b/%0h exp=1/60", m_hready[0], s_haddr); end
        next_cycle();
        s_hresp = 1'b0;
        set_m(1, IDLE, '0, 1'b0, SINGLE);
        #1;
        tests++; if (grant !== 1'b1 || data_owner !== 1'b1 || m_hresp[0] !== 1'b0) begin fails++; $display("FAIL err_after got=%0d/%0d/%0b exp=1/1/0", grant, data_owner, m_hresp[0]); end
        next_cycle();
    endtask

    task automatic test_wait_states();
        set_m(1, NONSEQ, 32'h70, 1'b0, SINGLE);
        #1;
        tests++; if (grant !== 1'b1 || s_haddr !== 32'h70) begin fails++; $display("FAIL wait_addr got=%0d/%0h exp=1/70", grant, s_haddr); end
        next_cycle();
        set_m(1, IDLE, '0, 1'b0, SINGLE);
        set_m(0, NONSEQ, 32'h80, 1'b0, SINGLE);
        s_hreadyout = 1'b0;
        for (int w = 1; w <= 3; w++) begin
            #1;
            tests++; if (grant !== 1'b1 || data_owner !== 1'b1) begin fails++; $display("FAIL wait_hold%0d got=%0d/%0d exp=1/1", w, grant, data_owner); end
            tests++; if (m_hready[1] !== 1'b0 || m_hready[0] !== 1'b0) begin fails++; $display("FAIL wait_ready%0d got=%0b%0b exp=00", w, m_hready[1], m_hready[0]); end
            next_cycle();
        end
        s_hreadyout = 1'b1;
        s_hrdata = 32'hDEADBEEF;
        #1;
        tests++; if (m_hrdata !== 32'hDEADBEEF || m_hready[1] !== 1'b1 || grant !== 1'b1) begin fails++; $display("FAIL wait_rdata got=%0h/%0b/%0d exp=deadbeef/1/1", m_hrdata, m_hready[1], grant); end
        next_cycle();
        #1;
        tests++; if (grant !== 1'b0 || s_haddr !== 32'h80) begin fails++; $display("FAIL wait_handover got=%0d/%0h exp=0/80", grant, s_haddr); end
        next_cycle();
        idle_all();
        next_cycle();
    endtask

    task automatic test_fixed_priority();
        for (int k = 0; k < 6; k++) begin
            set_m(0, NONSEQ, 32'h90 + 32'(4 * k), 1'b0, SINGLE);
            set_m(1, NONSEQ, 32'hA0, 1'b0, SINGLE);
            #1;
            tests++; if (grant !== 1'b0 || m_hready[1] !== 1'b0) begin fails++; $display("FAIL fixed_k%0d got=%0d/%0b exp=0/0", k, grant, m_hready[1]); end
            next_cycle();
        end
        idle_all();
        next_cycle();
    endtask

    initial begin
        test_reset();
`ifdef RENODE_AHB_ARBITER_FIXED_PRIORITY_EN
        test_fixed_priority();
`else
        test_round_robin();
        test_burst_hold();
        test_error();
        test_wait_states();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/renode_ahb_arbiter.md
# renode_ahb_arbiter

- Shares one AHB subordinate port between `NumManagers` AHB-Lite managers, such as several Renode-driven or HDL managers in front of one peripheral.
- Arbitrates at address-phase boundaries and holds a grant for the length of a burst.
- Stalls non-granted managers through their `hready`, then routes write data and responses by a registered data-phase owner.
- Sits between the manager-side AHB interfaces and the subordinate-side AHB interface in the co-simulation bus fabric.

## Interface
Parameters:
- `NumManagers`, default 2: number of requesters, 2..8.
- `AddressWidth`, default 32: `haddr` width.
- `DataWidth`, default 32: `hwdata`/`hrdata` width.

Ports (index `i` selects a manager; arrays are unpacked `[NumManagers]`):
- `hclk` in 1: bus clock. This is the only clock.
- `hresetn` in 1: asynchronous, active-low reset.
- `m_htrans[i]` in 2, `m_haddr[i]` in AddressWidth, `m_hwrite[i]` in 1, `m_hsize[i]` in 3, `m_hburst[i]` in 3, `m_hwdata[i]` in DataWidth: manager requests.
- `m_hready[i]` out 1: per-manager ready.
- `m_hresp[i]` out 1: per-manager response.
- `m_hrdata` out DataWidth: read data, broadcast to all managers.
- `s_htrans` out 2, `s_haddr` out AddressWidth, `s_hwrite` out 1, `s_hsize` out 3, `s_hburst` out 3, `s_hwdata` out DataWidth: subordinate request.
- `s_hready` out 1: subordinate `hready` input; equals `s_hreadyout`.
- `s_hreadyout` in 1, `s_hresp` in 1, `s_hrdata` in DataWidth: subordinate response.
- `grant` out $clog2(NumManagers): current address-phase owner.
- `data_owner` out $clog2(NumManagers): current data-phase owner.

## Operation
- Encodings: htrans Idle=0, Busy=1, Nonseq=2, Seq=3; hresp Okay=0, Error=1; hburst Single=0.
- Registered state:
  - `grant`
  - `data_owner`
  - `data_valid` (the data phase in flight is a real transfer)
  - `rr_last` (last granted index)
- Address mux: `s_htrans/haddr/hwrite/hsize/hburst` come from `m_*[grant]`.
- Data mux: `s_hwdata = m_hwdata[data_owner]`.
- Ready routing: `m_hready[i] = s_hreadyout` when `i == grant` or `i == data_owner`, else 0. A non-granted manager therefore holds its address until it is granted.
- Response routing:
  - `m_hresp[data_owner] = s_hresp`; all other managers see Okay.
  - `m_hrdata = s_hrdata` is combinational.
- Request: manager `i` requests when `m_htrans[i]` is Nonseq or Seq.
- Hold: the grant owner keeps the grant while its htrans is Seq or Busy, or Nonseq with `hburst != Single`.
- Release: the grant is released when the owner presents Idle, or Nonseq with Single.
- Arbitration: evaluated only in cycles with `s_hreadyout == 1` and no hold.
  - Next owner is the first requester in round-robin order starting at `rr_last+1`.
  - With no requester, the grant parks on the current owner.
  - The new grant takes effect in the next cycle. The new owner's held address then appears on `s_*` with no idle bubble.
- Data-phase tracking, in every cycle with `s_hreadyout == 1`:
  - `data_owner <= grant`
  - `data_valid <= (m_htrans[grant] ∈ {Nonseq, Seq})`
- Error response: the two-cycle error (`hresp` Error with `hreadyout` low, then high) reaches only `data_owner`. Arbitration may still move in the second error cycle.

## Timing
- Reset, asynchronous on `hresetn` low:
  - `grant = 0`, `data_owner = 0`, `data_valid = 0`, `rr_last = NumManagers-1`.
  - While reset is held: `s_htrans = Idle`, all `m_hready = 1`, all `m_hresp = Okay`, `m_hrdata = s_hrdata`.
- Reset in the middle of a transfer abandons it; the first cycle after deassertion is an address phase for manager 0.
- Latency:
  - Address path, data path and `hready` are combinational: zero added cycles for the owner.
  - Grant switch costs exactly one cycle, the arbitration cycle.
- Simultaneous requests from every manager: each is served once per rotation (round-robin fairness).
- Owner in the middle of a burst with others waiting: no switch until release.
- `s_hreadyout` low: `grant`, `data_owner` and `data_valid` all hold.
- Same manager as `grant` and `data_owner`: sees `s_hreadyout` once (no double count).

## Configuration
- `RENODE_AHB_ARBITER_FIXED_PRIORITY_EN`:
  - Defined: fixed priority, lowest index wins every arbitration; `rr_last` is not implemented.
  - Undefined: round-robin as described above.

## Test plan
- Reset with `hresetn` low mid-burst -> `grant=0`, `data_owner=0`, `s_htrans=Idle`, all `m_hready=1`; after release, manager 0 single write to 0x10 of 0xA5 -> subordinate sees the write in 2 cycles.
- Managers 0 and 1 issue Nonseq Single reads simultaneously, repeated 4 times -> grants alternate 0,1,0,1; each `m_hready` is low while the other owns the bus.
- Manager 1 runs an INCR4 burst from 0x100 while manager 0 requests -> all 4 beats go out contiguously; manager 0 is granted the cycle after manager 1 drives Idle.
- Subordinate returns Error on manager 0's write while manager 1 waits -> `m_hresp[0]` is Error for 2 cycles; `m_hresp[1]` stays Okay; manager 1 is granted afterwards.
- Subordinate inserts 3 wait states on a manager 1 read returning 0xDEADBEEF -> `grant`/`data_owner` stable; manager 1 reads 0xDEADBEEF.
- Build with `RENODE_AHB_ARBITER_FIXED_PRIORITY_EN` and manager 0 requesting continuously -> manager 1 is never granted.
